apb_master_bridge: RTL and testbench

- Upstream stage feeding the APB register-bank slaves.
- Accepts single CPU-side requests on a valid/ready interface and converts each into one APB SETUP/ACCESS transfer.
- Honours pready wait states and pslverr, and returns read data/error on a response channel with backpressure.
- One outstanding transfer at a time; no pipelining across transfers.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_timeout_ctr.sv | 38 +++
 rtl/apb_master_bridge.sv | 164 ++++++++++++++++
 tb/tb_apb_master_bridge.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
`timescale 1ns/1ps
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam int          APB_ADDR_W   = 32;
    localparam int          APB_DATA_W   = 32;
    localparam logic [31:0] APB_ERR_DATA = 32'hDEADBEEF;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/apb_timeout_ctr.sv
// ACCESS-phase wait counter used by the bridge when APB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module apb_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int             W    = $clog2(LIMIT + 1);
    localparam logic [W-1:0]   LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Expires on the edge where the count reaches LIMIT, so ACCESS lasts LIMIT cycles.
    assign expired_o = inc_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// CPU valid/ready request to single APB SETUP/ACCESS transfer, one at a time.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES without pready.
`timescale 1ns/1ps
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              apb_psel_o,
    output logic              apb_penable_o,
    output logic              apb_pwrite_o,
    output logic [ADDR_W-1:0] apb_paddr_o,
    output logic [DATA_W-1:0] apb_pwdata_o,
    input  logic [DATA_W-1:0] apb_prdata_i,
    input  logic              apb_pready_i,
    input  logic              apb_pslverr_i,
    output logic [1:0]        dbg_state_o
);

    // Handshakes: a beat transfers on a rising edge where valid and ready are both 1;
    // valid holds its payload until then and ready never depends on valid.

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be 1..65535");
    end

    apb_state_e        state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              timeout_hit;

`ifdef APB_TIMEOUT_EN
    logic access_wait;
    logic setup_phase;
    assign access_wait = (state_q == ST_ACCESS) && !apb_pready_i;
    assign setup_phase = (state_q == ST_SETUP);

    apb_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk_i     (clk_i),
        .resetn_i  (resetn_i),
        .clr_i     (setup_phase),
        .inc_i     (access_wait),
        .expired_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (is_misaligned(req_addr_i[1:0])) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d   = ST_SETUP;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                        pwrite_d  = req_write_i;
                        paddr_d   = req_addr_i;
                        pwdata_d  = req_write_i ? req_wdata_i : '0;
                    end
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                // A completing pready takes priority over a timeout in the same cycle.
                if (apb_pready_i) begin
                    state_d     = ST_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = apb_pslverr_i;
                    rsp_rdata_d = pwrite_q ? '0 : apb_prdata_i;
                end else if (timeout_hit) begin
                    state_d     = ST_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = DATA_W'(APB_ERR_DATA);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Held low while reset is asserted so every output reads 0 during reset.
    assign req_ready_o   = resetn_i && (state_q == ST_IDLE);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign apb_psel_o    = psel_q;
    assign apb_penable_o = penable_q;
    assign apb_pwrite_o  = pwrite_q;
    assign apb_paddr_o   = paddr_q;
    assign apb_pwdata_o  = pwdata_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: APB slave model plus a reference
// model of responses/latency; APB_TIMEOUT_EN adds timeout scenarios.
`timescale 1ns/1ps
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk;
    logic          resetn;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic [1:0]    dbg_state;

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i         (clk),
        .resetn_i      (resetn),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_write_i   (req_write),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .apb_psel_o    (psel),
        .apb_penable_o (penable),
        .apb_pwrite_o  (pwrite),
        .apb_paddr_o   (paddr),
        .apb_pwdata_o  (pwdata),
        .apb_prdata_i  (prdata),
        .apb_pready_i  (pready),
        .apb_pslverr_i (pslverr),
        .dbg_state_o   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- APB slave model and protocol monitor ----------------
    int            cfg_waits  = 0;
    logic          cfg_err    = 1'b0;
    logic          exp_pwrite = 1'b0;
    logic [AW-1:0] exp_paddr  = '0;
    logic [DW-1:0] exp_pwdata = '0;
    int            psel_pulses = 0;
    logic [DW-1:0] slv_mem [logic [AW-1:0]];

    initial begin
        logic          prev_psel;
        int            wcnt;
        logic [AW-1:0] s_addr;
        logic          s_write;
        logic [DW-1:0] s_wdata;
        prev_psel = 1'b0;
        wcnt      = 0;
        s_addr    = '0;
        s_write   = 1'b0;
        s_wdata   = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_psel = 1'b0;
                wcnt      = 0;
                pready    = 1'b0;
            end else begin
                if (psel && !prev_psel) begin
                    psel_pulses++;
                    chk("setup_penable", penable, 0);
                    chk("setup_paddr", paddr, exp_paddr);
                    chk("setup_pwrite", pwrite, exp_pwrite);
                    chk("setup_pwdata", pwdata, exp_pwdata);
                    s_addr  = paddr;
                    s_write = pwrite;
                    s_wdata = pwdata;
                end else if (psel) begin
                    chk("access_penable", penable, 1);
                    chk("access_paddr_stable", paddr, s_addr);
                    chk("access_pwrite_stable", pwrite, s_write);
                    chk("access_pwdata_stable", pwdata, s_wdata);
                end
                if (psel && penable) begin
                    if (wcnt >= cfg_waits) begin
                        pready  = 1'b1;
                        pslverr = cfg_err;
                        if (pwrite) begin
                            prdata = $urandom;
                            if (!cfg_err) slv_mem[paddr] = pwdata;
                        end else begin
                            prdata = slv_mem.exists(paddr) ? slv_mem[paddr] : '0;
                        end
                    end else begin
                        pready  = 1'b0;
                        pslverr = 1'($urandom_range(0, 1));
                        prdata  = $urandom;
                        wcnt++;
                    end
                end else begin
                    // Garbage outside ACCESS: the bridge must ignore it.
                    pready  = 1'($urandom_range(0, 1));
                    pslverr = 1'($urandom_range(0, 1));
                    prdata  = $urandom;
                    wcnt    = 0;
                end
                prev_psel = psel;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic [DW:0]   exp_q [$];

    function automatic logic [DW:0] ref_model(input logic w, input logic [AW-1:0] a,
                                              input logic [DW-1:0] d, input int waits,
                                              input logic e);
        logic [DW-1:0] rd;
        if (a % 4 != 0) return {1'b1, {DW{1'b0}}};
`ifdef APB_TIMEOUT_EN
        if (waits >= TO) return {1'b1, 32'hDEADBEEF};
`endif
        if (w) begin
            if (!e) ref_mem[a] = d;
            return {e, {DW{1'b0}}};
        end
        rd = ref_mem.exists(a) ? ref_mem[a] : {DW{1'b0}};
        return {e, rd};
    endfunction

    function automatic int ref_lat(input logic [AW-1:0] a, input int waits);
        if (a % 4 != 0) return 1;
`ifdef APB_TIMEOUT_EN
        if (waits >= TO) return 2 + TO;
`endif
        return 3 + waits;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int waits, input logic e);
        int n;
        cfg_waits  = waits;
        cfg_err    = e;
        exp_pwrite = w;
        exp_paddr  = a;
        exp_pwdata = w ? d : '0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_bound", n < 50, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int waits, input logic e, input int hold);
        logic [DW:0]   exp;
        logic [DW-1:0] held_rdata;
        logic          held_err;
        int            lat;
        int            k;
        int            base;
        exp_q.push_back(ref_model(w, a, d, waits, e));
        lat  = ref_lat(a, waits);
        base = psel_pulses;
        send_req(w, a, d, waits, e);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rsp_valid && k < 200);
        chk("rsp_latency", k, lat);
        exp = exp_q.pop_front();
        chk("rsp_err", rsp_err, exp[DW]);
        chk("rsp_rdata", rsp_rdata, exp[DW-1:0]);
        chk("apb_idle_in_resp", {psel, penable}, 0);
        chk("psel_pulse_count", psel_pulses, base + ((a % 4 != 0) ? 0 : 1));
        held_rdata = rsp_rdata;
        held_err   = rsp_err;
        if (hold > 0) begin
            req_valid = 1'b1;
            req_write = 1'($urandom_range(0, 1));
            req_addr  = 32'($urandom_range(0, 15)) * 4;
            req_wdata = $urandom;
        end
        repeat (hold) begin
            @(negedge clk);
            chk("rsp_hold_valid", rsp_valid, 1);
            chk("rsp_hold_rdata", rsp_rdata, held_rdata);
            chk("rsp_hold_err", rsp_err, held_err);
            chk("req_ready_in_resp", req_ready, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_released", rsp_valid, 0);
        chk("req_ready_after_hs", req_ready, 1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_state", dbg_state, 0);
        resetn = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", req_ready, 1);

        // Register-bank slave (one wait state), then read-back.
        do_req(1'b1, 32'h0000_0008, 32'h1234_5678, 1, 1'b0, 0);
        do_req(1'b0, 32'h0000_0008, 32'h0, 1, 1'b0, 0);
        // Misaligned read.
        do_req(1'b0, 32'h0000_0006, 32'h0, 1, 1'b0, 0);
        // Five wait states then pslverr on a write.
        do_req(1'b1, 32'h0000_0010, 32'hA5A5_0001, 5, 1'b1, 0);
        // Response backpressure for 3 cycles with a request pending.
        do_req(1'b0, 32'h0000_0010, 32'h0, 0, 1'b0, 3);
        // Zero-wait slave, top-of-range address, read with pslverr.
        do_req(1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 0, 1'b0, 0);
        do_req(1'b0, 32'hFFFF_FFFC, 32'h0, 0, 1'b1, 1);
        do_req(1'b1, 32'h0000_0003, 32'h1111_2222, 0, 1'b0, 2);

        for (int i = 0; i < 40; i++) begin
            logic          w;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 7)) * 4;
            if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
            d = $urandom;
            do_req(w, a, d, int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
                   int'($urandom_range(0, 2)));
        end

`ifdef APB_TIMEOUT_EN
        // Stuck pready aborts; pready exactly at the limit still completes normally.
        do_req(1'b0, 32'h0000_0020, 32'h0, 1000, 1'b0, 0);
        do_req(1'b1, 32'h0000_0024, 32'h7777_8888, TO - 1, 1'b0, 0);
        do_req(1'b0, 32'h0000_0024, 32'h0, TO - 1, 1'b0, 0);
`endif

        // Asynchronous reset in the middle of ACCESS: abandoned, no response.
        send_req(1'b1, 32'h0000_0030, 32'hBAD0_0030, 1000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_access", {psel, penable}, 2'b11);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_psel", psel, 0);
        chk("async_rst_penable", penable, 0);
        chk("async_rst_rsp_valid", rsp_valid, 0);
        chk("async_rst_req_ready", req_ready, 0);
        chk("async_rst_paddr", paddr, 0);
        chk("async_rst_pwdata", pwdata, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_no_rsp", rsp_valid, 0);
        chk("post_rst_idle", req_ready, 1);
        do_req(1'b0, 32'h0000_0030, 32'h0, 1, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
